// File: rtl/operand_writeback_select.sv
// rtl/operand_writeback_select.sv - EX operand A/B and WB write-data selection
// with a sticky reserved-select error register.
module operand_writeback_select (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ex_rs,
  input  logic [31:0] ex_rt,
  input  logic [31:0] ext_out,
  input  logic [31:0] mem_aluresult,
  input  logic [31:0] wb_aluresult,
  input  logic [31:0] wb_memdata,
  input  logic [31:0] wb_pc,
  input  logic [1:0]  forward_a,
  input  logic [1:0]  forward_b,
  input  logic        ex_alusrc,
  input  logic [1:0]  wb_memtoreg,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [31:0] reg_wdata,
  output logic [2:0]  sel_err
);

  logic [2:0]  r_sel_err;
  logic [31:0] w_link_addr;
  logic [2:0]  w_sel_bad;

  assign w_link_addr = wb_pc + 32'd4;

  always_comb begin
    alu_a = ex_rs;
    case (forward_a)
      2'b01:   alu_a = mem_aluresult;
      2'b10:   alu_a = wb_aluresult;
      default: alu_a = ex_rs;
    endcase
  end

  // The immediate wins over any forwarding path for operand B.
  always_comb begin
    alu_b = ex_rt;
    if (ex_alusrc) begin
      alu_b = ext_out;
    end else begin
      case (forward_b)
        2'b01:   alu_b = mem_aluresult;
        2'b10:   alu_b = wb_memdata;
        default: alu_b = ex_rt;
      endcase
    end
  end

  always_comb begin
    reg_wdata = wb_aluresult;
    case (wb_memtoreg)
      2'b01:   reg_wdata = wb_memdata;
      2'b10:   reg_wdata = w_link_addr;
      default: reg_wdata = wb_aluresult;
    endcase
  end

  assign w_sel_bad = {wb_memtoreg == 2'b11, forward_b == 2'b11, forward_a == 2'b11};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel_err <= 3'b000;
    end else begin
      r_sel_err <= r_sel_err | w_sel_bad;
    end
  end

  assign sel_err = r_sel_err;

endmodule

// File: tb/tb_operand_writeback_select.sv
// tb/tb_operand_writeback_select.sv - vector table, error-register sequences
// and randomized checks against a lookup-table reference model.
module tb_operand_writeback_select;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ex_rs, ex_rt, ext_out, mem_aluresult, wb_aluresult, wb_memdata, wb_pc;
  logic [1:0]  forward_a, forward_b, wb_memtoreg;
  logic        ex_alusrc;
  logic [31:0] alu_a, alu_b, reg_wdata;
  logic [2:0]  sel_err;

  int n_checks = 0;
  int n_errors = 0;
  logic [2:0] exp_err = 3'b000;

  always #5 clk = ~clk;

  operand_writeback_select dut (
    .clk(clk), .reset(reset),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ext_out(ext_out),
    .mem_aluresult(mem_aluresult), .wb_aluresult(wb_aluresult),
    .wb_memdata(wb_memdata), .wb_pc(wb_pc),
    .forward_a(forward_a), .forward_b(forward_b),
    .ex_alusrc(ex_alusrc), .wb_memtoreg(wb_memtoreg),
    .alu_a(alu_a), .alu_b(alu_b), .reg_wdata(reg_wdata), .sel_err(sel_err)
  );

  typedef struct {
    logic [1:0]  fa, fb;
    logic        src;
    logic [1:0]  m2r;
    logic [31:0] rs, rt, ext, mem, wba, wbm, pc;
    logic [31:0] ea, eb, ew;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input vec_t v);
    reset = rst;
    forward_a = v.fa; forward_b = v.fb; ex_alusrc = v.src; wb_memtoreg = v.m2r;
    ex_rs = v.rs; ex_rt = v.rt; ext_out = v.ext; mem_aluresult = v.mem;
    wb_aluresult = v.wba; wb_memdata = v.wbm; wb_pc = v.pc;
  endtask

  // Inputs are driven just after negedge: check data paths, clock once, check sel_err.
  task automatic run(input string tag, input logic [31:0] ea, input logic [31:0] eb,
                     input logic [31:0] ew);
    #1;
    chk({tag, " alu_a"}, alu_a, ea);
    chk({tag, " alu_b"}, alu_b, eb);
    chk({tag, " reg_wdata"}, reg_wdata, ew);
    @(posedge clk);
    if (reset) exp_err = 3'b000;
    else exp_err = exp_err | {wb_memtoreg == 2'b11, forward_b == 2'b11, forward_a == 2'b11};
    @(negedge clk);
    chk({tag, " sel_err"}, {29'd0, sel_err}, {29'd0, exp_err});
  endtask

  // Reference: each output is a lookup into a table of its candidate sources.
  task automatic model(input vec_t v, output logic [31:0] ea, output logic [31:0] eb,
                       output logic [31:0] ew);
    logic [31:0] a_src[4];
    logic [31:0] b_src[4];
    logic [31:0] w_src[4];
    a_src = '{v.rs, v.mem, v.wba, v.rs};
    b_src = '{v.rt, v.mem, v.wbm, v.rt};
    w_src = '{v.wba, v.wbm, v.pc + 32'd4, v.wba};
    ea = a_src[v.fa];
    eb = v.src ? v.ext : b_src[v.fb];
    ew = w_src[v.m2r];
  endtask

  initial begin
    vec_t v;
    logic [31:0] ea, eb, ew;

    // fa fb src m2r rs rt ext mem wba wbm pc | ea eb ew
    vecs.push_back('{2'd0, 2'd0, 1'b0, 2'd0, 32'h11111111, 32'h0, 32'h0, 32'h22222222, 32'h33333333, 32'h0, 32'h0, 32'h11111111, 32'h0, 32'h33333333});
    vecs.push_back('{2'd1, 2'd0, 1'b0, 2'd0, 32'h11111111, 32'h0, 32'h0, 32'h22222222, 32'h33333333, 32'h0, 32'h0, 32'h22222222, 32'h0, 32'h33333333});
    vecs.push_back('{2'd2, 2'd0, 1'b0, 2'd0, 32'h11111111, 32'h0, 32'h0, 32'h22222222, 32'h33333333, 32'h0, 32'h0, 32'h33333333, 32'h0, 32'h33333333});
    vecs.push_back('{2'd3, 2'd0, 1'b0, 2'd0, 32'h11111111, 32'h0, 32'h0, 32'h22222222, 32'h33333333, 32'h0, 32'h0, 32'h11111111, 32'h0, 32'h33333333});
    vecs.push_back('{2'd0, 2'd1, 1'b1, 2'd0, 32'h0, 32'hA, 32'hFFFF8000, 32'h12345678, 32'h5, 32'hBB, 32'h0, 32'h0, 32'hFFFF8000, 32'h5});
    vecs.push_back('{2'd0, 2'd0, 1'b0, 2'd0, 32'h0, 32'hA, 32'hFFFF8000, 32'h12345678, 32'h5, 32'hBB, 32'h0, 32'h0, 32'hA, 32'h5});
    vecs.push_back('{2'd0, 2'd2, 1'b0, 2'd0, 32'h0, 32'hA, 32'hFFFF8000, 32'h12345678, 32'h5, 32'hBB, 32'h0, 32'h0, 32'hBB, 32'h5});
    vecs.push_back('{2'd0, 2'd1, 1'b0, 2'd0, 32'h0, 32'hA, 32'hFFFF8000, 32'h12345678, 32'h5, 32'hBB, 32'h0, 32'h0, 32'h12345678, 32'h5});
    vecs.push_back('{2'd0, 2'd0, 1'b0, 2'd0, 32'h77, 32'h88, 32'h0, 32'h0, 32'h5, 32'h6, 32'h00003010, 32'h77, 32'h88, 32'h5});
    vecs.push_back('{2'd0, 2'd0, 1'b0, 2'd1, 32'h77, 32'h88, 32'h0, 32'h0, 32'h5, 32'h6, 32'h00003010, 32'h77, 32'h88, 32'h6});
    vecs.push_back('{2'd0, 2'd0, 1'b0, 2'd2, 32'h77, 32'h88, 32'h0, 32'h0, 32'h5, 32'h6, 32'h00003010, 32'h77, 32'h88, 32'h00003014});
    vecs.push_back('{2'd0, 2'd0, 1'b0, 2'd3, 32'h77, 32'h88, 32'h0, 32'h0, 32'h5, 32'h6, 32'h00003010, 32'h77, 32'h88, 32'h5});
    vecs.push_back('{2'd0, 2'd0, 1'b0, 2'd2, 32'h77, 32'h88, 32'h0, 32'h0, 32'h5, 32'h6, 32'hFFFFFFFC, 32'h77, 32'h88, 32'h0});

    v = '{2'd0, 2'd0, 1'b0, 2'd0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h0, 32'h0, 32'h0};
    @(negedge clk);
    drive(1'b1, v);
    run("reset", 32'h1, 32'h2, 32'h5);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(1'b0, vecs[i]);
      run($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb, vecs[i].ew);
      if (i == 3) chk("fa11 sel_err", {29'd0, sel_err}, 32'd1);
    end

    // Error register sequence.
    v = '{2'd0, 2'd0, 1'b0, 2'd0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h0, 32'h0, 32'h0};
    drive(1'b1, v);
    run("err clr", 32'h1, 32'h2, 32'h5);
    chk("err clr const", {29'd0, sel_err}, 32'd0);
    v.fa = 2'd3; v.fb = 2'd3; v.m2r = 2'd3; v.src = 1'b1;
    drive(1'b0, v);
    run("err all", 32'h1, 32'h3, 32'h5);
    chk("err all const", {29'd0, sel_err}, 32'd7);
    v.fa = 2'd0; v.fb = 2'd0; v.m2r = 2'd0; v.src = 1'b0;
    drive(1'b0, v);
    run("err sticky", 32'h1, 32'h2, 32'h5);
    chk("err sticky const", {29'd0, sel_err}, 32'd7);
    drive(1'b1, v);
    run("err reset", 32'h1, 32'h2, 32'h5);
    chk("err reset const", {29'd0, sel_err}, 32'd0);
    v.fa = 2'd3;
    drive(1'b1, v);
    run("err rst prio", 32'h1, 32'h2, 32'h5);
    chk("err rst prio const", {29'd0, sel_err}, 32'd0);

    // Randomized stimulus with occasional mid-run reset.
    for (int i = 0; i < 300; i++) begin
      v.fa = 2'($urandom_range(0, 3));
      v.fb = 2'($urandom_range(0, 3));
      v.src = 1'($urandom_range(0, 1));
      v.m2r = 2'($urandom_range(0, 3));
      v.rs = $urandom; v.rt = $urandom; v.ext = $urandom; v.mem = $urandom;
      v.wba = $urandom; v.wbm = $urandom;
      v.pc = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : $urandom;
      model(v, ea, eb, ew);
      drive(($urandom_range(0, 7) == 0), v);
      run($sformatf("rand%0d", i), ea, eb, ew);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/operand_writeback_select.md
# operand_writeback_select

Data-select block for the five-stage MIPS pipeline, merging three selectors: EX-stage ALU operand A with forwarding, EX-stage ALU operand B with immediate selection and forwarding, and WB-stage register write-data selection. All data paths are combinational, so selected values are available in the same cycle their selects change. One registered, sticky select-error status vector records reserved select encodings for debug.

## Interface
- No parameters; all data paths are 32 bits.
- clk  input  1  pipeline clock; only the error register uses it.
- reset  input  1  synchronous, active-high; clears the error register only.
- ex_rs  input  32  operand A from the ID/EX register (rs value).
- ex_rt  input  32  rt value from the ID/EX register.
- ext_out  input  32  extended 16-bit immediate, EX stage.
- mem_aluresult  input  32  ALU result held in the EX/MEM register.
- wb_aluresult  input  32  ALU result held in the MEM/WB register.
- wb_memdata  input  32  load data held in the MEM/WB register.
- wb_pc  input  32  instruction address carried to WB (address of that instruction).
- forward_a  input  2  forwarding select for operand A.
- forward_b  input  2  forwarding select for operand B.
- ex_alusrc  input  1  1 = operand B is the immediate.
- wb_memtoreg  input  2  write-back data select.
- alu_a  output  32  selected ALU operand A.
- alu_b  output  32  selected ALU operand B.
- reg_wdata  output  32  data written to the register file.
- sel_err  output  3  sticky error flags: bit0 = forward_a, bit1 = forward_b, bit2 = wb_memtoreg.

## Operation
- alu_a, selected by forward_a:
  - 00 → ex_rs.
  - 01 → mem_aluresult (EX/MEM forward).
  - 10 → wb_aluresult (MEM/WB forward).
  - 11 → ex_rs (reserved).
- alu_b:
  - ex_alusrc = 1 → ext_out, regardless of forward_b.
  - Otherwise, selected by forward_b: 00 → ex_rt; 01 → mem_aluresult; 10 → wb_memdata (load-to-use forward); 11 → ex_rt (reserved).
- reg_wdata, selected by wb_memtoreg:
  - 00 → wb_aluresult.
  - 01 → wb_memdata.
  - 10 → wb_pc + 4 (link address for jal/jalr); 32-bit modulo add, so 0xFFFFFFFC gives 0x00000000.
  - 11 → wb_aluresult (reserved).
- sel_err:
  - A bit is set when its select equals 11 at a rising clk edge.
  - forward_b = 11 sets bit1 even when ex_alusrc = 1.
  - Bits are sticky; only reset clears them.
  - More than one bit may set in the same cycle.
- No internal state other than sel_err. Data outputs never depend on clk or reset.

## Timing
- Data outputs: purely combinational, zero-cycle latency. No latches; every select combination is fully decoded.
- sel_err is updated at rising clk:
  - reset = 1 → sel_err ← 000. Reset has priority over simultaneous error conditions.
  - Otherwise, sel_err ← sel_err | {memtoreg==11, forward_b==11, forward_a==11}.
- Reset value of sel_err is 000. Data outputs have no reset value; they follow their inputs during and after reset.
- An error flag becomes visible one cycle after the offending select is sampled.
- Asserting reset mid-operation changes no data output.

## Test plan
- Operand A forwarding: ex_rs=0x11111111, mem_aluresult=0x22222222, wb_aluresult=0x33333333; sweep forward_a 00/01/10/11 → alu_a = 0x11111111 / 0x22222222 / 0x33333333 / 0x11111111 in the same cycle. After the 11 sample, sel_err = 001 on the next clk.
- Operand B immediate priority: ex_alusrc=1, ext_out=0xFFFF8000, forward_b=01 → alu_b=0xFFFF8000. Then ex_alusrc=0, ex_rt=0x0000000A, wb_memdata=0x000000BB:
  - forward_b=00 → alu_b=0x0000000A.
  - forward_b=10 → alu_b=0x000000BB.
  - forward_b=01 → alu_b=mem_aluresult.
- Write-back select: wb_aluresult=0x5, wb_memdata=0x6, wb_pc=0x00003010; wb_memtoreg 00/01/10/11 → reg_wdata = 0x5 / 0x6 / 0x00003014 / 0x5.
- PC wrap: wb_pc=0xFFFFFFFC, wb_memtoreg=10 → reg_wdata=0x00000000.
- Error register: hold forward_a=11, forward_b=11 and wb_memtoreg=11 for one cycle → sel_err=111 next cycle. Return all selects to 00 → sel_err stays 111. Assert reset for one clk → sel_err=000. Assert reset together with forward_a=11 → sel_err stays 000.
